tx_frame_controller: RTL and testbench

//   Sequences the BPSK transmit path: buffers bytes arriving from the UART

---
 rtl/tx_frame_controller.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_tx_frame_controller.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_controller.sv
// -----------------------------------------------------------------------------
// tx_frame_controller
//
// Buffers bytes from the UART data buffer in a first-word fall-through FIFO and
// frames them for the BPSK modulator as:
//   preamble (alternating, first bit 1) | sync word (MSB first) |
//   length byte (MSB first) | payload bytes (MSB first) | silent gap.
// A frame starts when FRAME_BYTES bytes are buffered, or when the FIFO has sat
// non-empty in IDLE for TIMEOUT_CYC cycles. The modulator pulls one bit per
// ser_next strobe; with no strobe the offered bit is held.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   in_data     byte from the UART buffer
//   in_valid    in_data valid; accepted when in_valid & in_ready
//   in_ready    FIFO not full
//   ser_next    1-clk strobe from modulator: current ser_bit consumed
//   ser_bit     bit currently offered to the modulator
//   tx_active   modulator enable, high from PREAMBLE through PAYLOAD
//   frame_done  1-clk pulse after the last payload bit is consumed
//   fifo_level  bytes held in the FIFO (0..2**FIFO_AW)
//   overflow    sticky flag: a push was attempted while full
// -----------------------------------------------------------------------------
module tx_frame_controller #(
    parameter int          FIFO_AW       = 4,
    parameter int          FRAME_BYTES   = 8,
    parameter int          TIMEOUT_CYC   = 125000,
    parameter int          PREAMBLE_BITS = 32,
    parameter logic [15:0] SYNC_WORD     = 16'hD391,
    parameter int          GAP_CYC       = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               ser_next,
    output logic               ser_bit,
    output logic               tx_active,
    output logic               frame_done,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow
);

    localparam int DEPTH = 2 ** FIFO_AW;
    // Bit counter must hold the longest field index (preamble or 16-bit sync).
    localparam int CW    = $clog2((PREAMBLE_BITS > 16) ? PREAMBLE_BITS : 16);
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam int GW    = $clog2(GAP_CYC + 1);

    localparam logic [FIFO_AW:0]   LVL_ZERO  = {(FIFO_AW + 1){1'b0}};
    localparam logic [FIFO_AW:0]   LVL_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   LVL_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_FRAME = (FIFO_AW + 1)'(FRAME_BYTES);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = (FIFO_AW)'(1);
    localparam logic [CW-1:0]      CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]      PRE_LAST  = CW'(PREAMBLE_BITS - 1);
    localparam logic [CW-1:0]      SYNC_LAST = CW'(15);
    localparam logic [CW-1:0]      LEN_LAST  = CW'(7);
    localparam logic [TW-1:0]      TMR_ZERO  = {TW{1'b0}};
    localparam logic [TW-1:0]      TMR_ONE   = TW'(1);
    localparam logic [TW-1:0]      TMR_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0]      GAP_ZERO  = {GW{1'b0}};
    localparam logic [GW-1:0]      GAP_ONE   = GW'(1);
    localparam logic [GW-1:0]      GAP_LAST  = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SYNC     = 3'd2,
        ST_LEN      = 3'd3,
        ST_PAYLOAD  = 3'd4,
        ST_GAP      = 3'd5
    } state_t;

    state_t state_q, state_d;

    // FIFO storage and bookkeeping
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               overflow_q;
    logic               in_ready_s;
    logic               push_s;
    logic               pop_s;
    logic [7:0]         head_s;

    // Framing datapath
    logic [CW-1:0] bitcnt_q,    bitcnt_d;
    logic [7:0]    bytecnt_q,   bytecnt_d;
    logic [7:0]    frame_len_q, frame_len_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic [GW-1:0] gapcnt_q,    gapcnt_d;
    logic          tx_active_q, tx_active_d;
    logic          frame_done_q, frame_done_d;
    logic          ser_bit_s;
    logic          byte_end_s;

    assign in_ready_s = (count_q != LVL_FULL);
    assign push_s     = in_valid & in_ready_s;
    assign head_s     = mem_q[rd_ptr_q];
    assign byte_end_s = (bitcnt_q[2:0] == 3'd7);

    // FIFO data array write port (storage needs no reset).
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= {FIFO_AW{1'b0}};
            rd_ptr_q   <= {FIFO_AW{1'b0}};
            count_q    <= LVL_ZERO;
            overflow_q <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + LVL_ONE;
                2'b01:   count_q <= count_q - LVL_ONE;
                default: count_q <= count_q;
            endcase
            if (in_valid && !in_ready_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; each field ends on the strobe consuming its last bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if ((count_q >= LVL_FRAME) ||
                    ((count_q != LVL_ZERO) && (timer_q == TMR_LAST))) begin
                    state_d = ST_PREAMBLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (ser_next && (bitcnt_q == PRE_LAST)) begin
                    state_d = ST_SYNC;
                end else begin
                    state_d = ST_PREAMBLE;
                end
            end
            ST_SYNC: begin
                if (ser_next && (bitcnt_q == SYNC_LAST)) begin
                    state_d = ST_LEN;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_LEN: begin
                if (ser_next && (bitcnt_q == LEN_LAST)) begin
                    state_d = ST_PAYLOAD;
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_PAYLOAD: begin
                if (ser_next && byte_end_s && (bytecnt_q == (frame_len_q - 8'd1))) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_GAP: begin
                if (gapcnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: offered bit, FIFO pop and next values of the framing counters.
    always_comb begin
        ser_bit_s    = 1'b0;
        pop_s        = 1'b0;
        bitcnt_d     = bitcnt_q;
        bytecnt_d    = bytecnt_q;
        frame_len_d  = frame_len_q;
        timer_d      = TMR_ZERO;
        gapcnt_d     = GAP_ZERO;
        frame_done_d = 1'b0;
        tx_active_d  = (state_d == ST_PREAMBLE) || (state_d == ST_SYNC) ||
                       (state_d == ST_LEN) || (state_d == ST_PAYLOAD);
        case (state_q)
            ST_IDLE: begin
                bitcnt_d  = CNT_ZERO;
                bytecnt_d = 8'd0;
                if (state_d == ST_PREAMBLE) begin
                    // Length is frozen here; bytes arriving later wait for the next frame.
                    frame_len_d = (count_q >= LVL_FRAME) ? 8'(FRAME_BYTES) : 8'(count_q);
                    timer_d     = TMR_ZERO;
                end else if (push_s) begin
                    timer_d = TMR_ZERO;
                end else if (count_q != LVL_ZERO) begin
                    timer_d = timer_q + TMR_ONE;
                end else begin
                    timer_d = timer_q;
                end
            end
            ST_PREAMBLE: begin
                ser_bit_s = ~bitcnt_q[0];
                if (ser_next) begin
                    bitcnt_d = (state_d != state_q) ? CNT_ZERO : (bitcnt_q + CNT_ONE);
                end else begin
                    bitcnt_d = bitcnt_q;
                end
            end
            ST_SYNC: begin
                ser_bit_s = SYNC_WORD[4'd15 - bitcnt_q[3:0]];
                if (ser_next) begin
                    bitcnt_d = (state_d != state_q) ? CNT_ZERO : (bitcnt_q + CNT_ONE);
                end else begin
                    bitcnt_d = bitcnt_q;
                end
            end
            ST_LEN: begin
                ser_bit_s = frame_len_q[3'd7 - bitcnt_q[2:0]];
                if (ser_next) begin
                    bitcnt_d = (state_d != state_q) ? CNT_ZERO : (bitcnt_q + CNT_ONE);
                end else begin
                    bitcnt_d = bitcnt_q;
                end
            end
            ST_PAYLOAD: begin
                ser_bit_s = head_s[3'd7 - bitcnt_q[2:0]];
                if (ser_next && byte_end_s) begin
                    // Consuming the LSB retires the head byte.
                    pop_s        = 1'b1;
                    bitcnt_d     = CNT_ZERO;
                    bytecnt_d    = bytecnt_q + 8'd1;
                    frame_done_d = (state_d == ST_GAP);
                end else if (ser_next) begin
                    bitcnt_d = bitcnt_q + CNT_ONE;
                end else begin
                    bitcnt_d = bitcnt_q;
                end
            end
            ST_GAP: begin
                bitcnt_d = CNT_ZERO;
                if (state_d == ST_IDLE) begin
                    gapcnt_d = GAP_ZERO;
                end else begin
                    gapcnt_d = gapcnt_q + GAP_ONE;
                end
            end
            default: begin
                bitcnt_d  = CNT_ZERO;
                bytecnt_d = 8'd0;
            end
        endcase
    end

    // Framing counters and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitcnt_q     <= CNT_ZERO;
            bytecnt_q    <= 8'd0;
            frame_len_q  <= 8'd0;
            timer_q      <= TMR_ZERO;
            gapcnt_q     <= GAP_ZERO;
            tx_active_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            bitcnt_q     <= bitcnt_d;
            bytecnt_q    <= bytecnt_d;
            frame_len_q  <= frame_len_d;
            timer_q      <= timer_d;
            gapcnt_q     <= gapcnt_d;
            tx_active_q  <= tx_active_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign ser_bit    = ser_bit_s;
    assign tx_active  = tx_active_q;
    assign frame_done = frame_done_q;
    assign fifo_level = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_tx_frame_controller.sv
// Scoreboard bench for tx_frame_controller. Stimulus queues the expected frame
// bits and frame end positions; a modulator/monitor process consumes bits and
// compares them as the DUT offers them.
module tb_tx_frame_controller;

    localparam int TMO = 200;
    localparam int GAP = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ser_next;
    logic       ser_bit;
    logic       tx_active;
    logic       frame_done;
    logic [4:0] fifo_level;
    logic       overflow;

    tx_frame_controller #(
        .FIFO_AW      (4),
        .FRAME_BYTES  (8),
        .TIMEOUT_CYC  (TMO),
        .PREAMBLE_BITS(32),
        .SYNC_WORD    (16'hD391),
        .GAP_CYC      (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_next  (ser_next),
        .ser_bit   (ser_bit),
        .tx_active (tx_active),
        .frame_done(frame_done),
        .fifo_level(fifo_level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit exp_bits[$];
    int exp_done[$];
    int bit_idx      = 0;
    int queued_total = 0;
    int done_cnt     = 0;
    int low_run      = 0;
    int last_gap     = 0;
    bit mod_en       = 1'b0;
    bit stall        = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue one frame: preamble, sync, length n, payload first, first+1, ...
    task automatic expect_frame(input int n, input logic [7:0] first);
        logic [15:0] sw;
        logic [7:0]  len;
        logic [7:0]  v;
        sw  = 16'hD391;
        len = 8'(n);
        for (int i = 0; i < 32; i++) exp_bits.push_back((i % 2) == 0);
        for (int i = 15; i >= 0; i--) exp_bits.push_back(sw[i]);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(len[i]);
        for (int b = 0; b < n; b++) begin
            v = first + 8'(b);
            for (int i = 7; i >= 0; i--) exp_bits.push_back(v[i]);
        end
        queued_total += 56 + 8 * n;
        exp_done.push_back(queued_total);
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
    endtask

    task automatic push_end();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(done_cnt >= target), 1);
    endtask

    task automatic wait_bits(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (bit_idx < target && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        check(name, bit_idx, target);
    endtask

    // Modulator model plus monitor: checks each offered bit, then strobes it.
    initial begin
        bit e;
        int end_pos;
        ser_next = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ser_next = 1'b0;
            end else begin
                if (frame_done) begin
                    if (exp_done.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_done: got unexpected pulse at bit %0d", bit_idx);
                    end else begin
                        end_pos = exp_done.pop_front();
                        check("frame_done_pos", bit_idx, end_pos);
                    end
                    done_cnt++;
                end
                if (!tx_active) begin
                    low_run++;
                end else begin
                    if (low_run > 0) last_gap = low_run;
                    low_run = 0;
                end
                if (mod_en && !stall && tx_active) begin
                    if (exp_bits.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ser_bit: got unexpected bit %0b at %0d", ser_bit, bit_idx);
                    end else begin
                        e = exp_bits.pop_front();
                        check($sformatf("ser_bit#%0d", bit_idx), int'(ser_bit), int'(e));
                    end
                    bit_idx++;
                    ser_next = 1'b1;
                end else begin
                    ser_next = 1'b0;
                end
            end
        end
    end

    initial begin
        int cnt;
        int bad;
        int start;
        bit held;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",   int'(in_ready),   1);
        check("rst_tx_active",  int'(tx_active),  0);
        check("rst_ser_bit",    int'(ser_bit),    0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_level",      int'(fifo_level), 0);
        check("rst_overflow",   int'(overflow),   0);
        @(posedge clk);
        #2 rst = 1'b0;
        mod_en = 1'b1;

        // 1: full frame of 8 bytes, starts on the edge after level reaches 8
        expect_frame(8, 8'h01);
        for (int i = 0; i < 8; i++) push_byte(8'(i + 1));
        push_end();
        check("t1_level8", int'(fifo_level), 8);
        check("t1_not_yet_active", int'(tx_active), 0);
        @(negedge clk);
        check("t1_active", int'(tx_active), 1);
        wait_done(1, 400, "t1_done");
        @(negedge clk);
        check("t1_level0", int'(fifo_level), 0);
        repeat (GAP + 5) @(negedge clk);

        // 2: single byte sent after the idle timeout
        expect_frame(1, 8'hA5);
        push_byte(8'hA5);
        push_end();
        cnt = 1;
        while (!tx_active && cnt < TMO + 50) begin
            @(negedge clk);
            cnt++;
        end
        // Frame starts TMO edges after the push edge, seen at the following negedge.
        check("t2_timeout_start", cnt, TMO + 1);
        wait_done(2, 200, "t2_done");
        bad = 0;
        repeat (GAP) begin
            @(negedge clk);
            if (tx_active) bad++;
        end
        check("t2_gap_quiet", bad, 0);
        repeat (5) @(negedge clk);

        // 3: stalled modulator, fill FIFO, overflow, then two frames
        mod_en = 1'b0;
        expect_frame(8, 8'h50);
        expect_frame(8, 8'h58);
        for (int i = 0; i < 16; i++) push_byte(8'h50 + 8'(i));
        push_end();
        check("t3_in_ready", int'(in_ready),   0);
        check("t3_level16",  int'(fifo_level), 16);
        check("t3_active",   int'(tx_active),  1);
        check("t3_no_ovf",   int'(overflow),   0);
        push_byte(8'hEE);
        push_end();
        check("t3_overflow",   int'(overflow),   1);
        check("t3_level_hold", int'(fifo_level), 16);
        mod_en = 1'b1;
        wait_done(3, 600, "t3_done1");
        cnt = 0;
        while (!tx_active && cnt < GAP + 50) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        // GAP cycles in GAP plus one IDLE cycle before PREAMBLE.
        check("t3_gap_len", last_gap, GAP + 1);
        wait_done(4, 600, "t3_done2");
        repeat (GAP + 5) @(negedge clk);

        // 4: push coinciding with a payload pop
        start = queued_total;
        expect_frame(8, 8'h21);
        expect_frame(1, 8'h99);
        for (int i = 0; i < 8; i++) push_byte(8'h21 + 8'(i));
        push_end();
        wait_bits(start + 63, 400, "t4_reach_pop");
        in_valid = 1'b1;
        in_data  = 8'h99;
        @(posedge clk);
        #2 in_valid = 1'b0;
        check("t4_level_unchanged", int'(fifo_level), 8);
        wait_done(5, 400, "t4_done1");
        wait_done(6, TMO + GAP + 300, "t4_done2");
        repeat (GAP + 5) @(negedge clk);

        // 6: long stall inside the preamble
        start = queued_total;
        expect_frame(8, 8'h31);
        for (int i = 0; i < 8; i++) push_byte(8'h31 + 8'(i));
        push_end();
        wait_bits(start + 3, 400, "t6_reach_pre");
        stall = 1'b1;
        held  = exp_bits[0];
        @(negedge clk);
        check("t6_held_bit", int'(ser_bit), 0);
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (ser_bit !== held || !tx_active) bad++;
        end
        check("t6_stall_stable", bad, 0);
        stall = 1'b0;
        wait_done(7, 400, "t6_done");
        repeat (GAP + 5) @(negedge clk);

        // 5: asynchronous reset in the middle of the payload
        start = queued_total;
        expect_frame(8, 8'h41);
        for (int i = 0; i < 8; i++) push_byte(8'h41 + 8'(i));
        push_end();
        wait_bits(start + 60, 400, "t5_reach_payload");
        check("t5_ovf_sticky", int'(overflow), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_tx_active", int'(tx_active),  0);
        check("t5_ser_bit",   int'(ser_bit),    0);
        check("t5_level",     int'(fifo_level), 0);
        check("t5_overflow",  int'(overflow),   0);
        check("t5_in_ready",  int'(in_ready),   1);
        exp_bits.delete();
        exp_done.delete();
        queued_total = bit_idx;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        bad = 0;
        repeat (TMO + GAP + 50) begin
            @(negedge clk);
            if (tx_active || fifo_level != 5'd0 || frame_done) bad++;
        end
        check("t5_idle_after_rst", bad, 0);
        check("t5_no_done", done_cnt, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
